// File: rtl/spi_temp_pkg.sv
// Shared types and constants for the SPI temperature-sensor reader.
//   spi_rd_state_t : frame FSM states (idle, CS setup, SCLK high phase, SCLK low phase)
//   FRAME_W_DEF    : default bits per sensor frame
//   DIV_MIN        : smallest legal SCLK half-period in clk_in cycles
package spi_temp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow
    } spi_rd_state_t;

    localparam int unsigned FRAME_W_DEF = 16;
    localparam int unsigned DIV_MIN     = 2;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer for the SPI reader.
// Counts clk_in cycles and pulses tick for one cycle when the count reaches DIV-1,
// then restarts from zero. A synchronous clear holds the count at zero.
// Ports:
//   clk_in : system clock
//   rst    : asynchronous active-high reset
//   clear  : synchronous clear, also suppresses tick
//   tick   : one-cycle pulse at the end of each DIV-cycle phase
module spi_tick_gen
    import spi_temp_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    if (DIV < DIV_MIN) begin : g_bad_div
        $error("spi_tick_gen: DIV below DIV_MIN");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = !clear && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_temp_reader.sv
// SPI initiator that reads one FRAME_W-bit frame from a temperature sensor per request.
// SCLK (mode 0) is produced from a clock-enabled flop; no derived clock is used.
// MISO is shifted in MSB-first on each SCLK rising edge.
// Ports:
//   clk_in : system clock, all logic on its rising edge
//   rst    : asynchronous active-high reset
//   start  : request one frame, sampled only while idle
//   busy   : high from start acceptance until the frame completes
//   done   : one-cycle pulse, data valid from this cycle
//   data   : last completed frame, MSB = first bit received
//   sclk   : SPI clock, idle low
//   cs_n   : chip select, active low
//   miso   : sensor serial data, changes on falling SCLK
module spi_temp_reader
    import spi_temp_pkg::*;
#(
    parameter int unsigned DIV     = 4,
    parameter int unsigned FRAME_W = FRAME_W_DEF
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] data,
    output logic               sclk,
    output logic               cs_n,
    input  logic               miso
);

    localparam int unsigned BW = $clog2(FRAME_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);

    if (DIV < DIV_MIN || DIV > 255) begin : g_bad_div
        $error("spi_temp_reader: DIV must be within 2..255");
    end
    if (FRAME_W < 2) begin : g_bad_frame
        $error("spi_temp_reader: FRAME_W must be at least 2");
    end

    spi_rd_state_t      state_q, state_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick;
    logic               tick_clear;

    // Idle keeps the timer parked at zero so each frame starts with a full setup phase.
    spi_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_in (clk_in),
        .rst    (rst),
        .clear  (tick_clear),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        sreg_d     = sreg_q;
        data_d     = data_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tick_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                tick_clear = 1'b1;
                if (start) begin
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StHigh;
                    sclk_d  = 1'b1;
                    sreg_d  = {sreg_q[FRAME_W-2:0], miso};
                end
            end
            StHigh: begin
                if (tick) begin
                    state_d = StLow;
                    sclk_d  = 1'b0;
                end
            end
            StLow: begin
                if (tick) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = StIdle;
                        cs_n_d  = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        data_d  = sreg_q;
                    end else begin
                        state_d = StHigh;
                        bit_d   = bit_q + BW'(1);
                        sclk_d  = 1'b1;
                        // Sample on the same edge that raises SCLK; the sensor
                        // moved MISO a full half-period earlier.
                        sreg_d  = {sreg_q[FRAME_W-2:0], miso};
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            bit_q   <= '0;
            sreg_q  <= '0;
            data_q  <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            data_q  <= data_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sclk = sclk_q;
    assign cs_n = cs_n_q;
    assign busy = busy_q;
    assign done = done_q;
    assign data = data_q;

endmodule

// File: tb/tb_spi_temp_reader.sv
// Bench for spi_temp_reader: one instance with DIV=4 and one with DIV=2, each fed by a
// behavioural sensor that presents its frame MSB-first and advances on falling SCLK.
module tb_spi_temp_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start_v = 2'b00;
    logic [1:0]  miso_v, sclk_v, cs_n_v, busy_v, done_v;
    logic [15:0] data0, data1;
    logic [15:0] frame0 = 16'h0000;
    logic [15:0] frame1 = 16'h0000;
    int          nf0 = 0;
    int          nf1 = 0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          rises[2], sclk_hi[2], cs_low[2], busy_hi[2], dones[2];
    int          done_cyc[2], first_rise[2], last_rise[2], bad_period[2];
    logic [15:0] done_data[2];
    logic        sclk_prev[2];

    always #5 clk = ~clk;

    spi_temp_reader #(
        .DIV     (4),
        .FRAME_W (16)
    ) dut4 (
        .clk_in (clk),
        .rst    (rst),
        .start  (start_v[0]),
        .busy   (busy_v[0]),
        .done   (done_v[0]),
        .data   (data0),
        .sclk   (sclk_v[0]),
        .cs_n   (cs_n_v[0]),
        .miso   (miso_v[0])
    );

    spi_temp_reader #(
        .DIV     (2),
        .FRAME_W (16)
    ) dut2 (
        .clk_in (clk),
        .rst    (rst),
        .start  (start_v[1]),
        .busy   (busy_v[1]),
        .done   (done_v[1]),
        .data   (data1),
        .sclk   (sclk_v[1]),
        .cs_n   (cs_n_v[1]),
        .miso   (miso_v[1])
    );

    // Sensor: bit index = number of falling SCLK edges since CS_n went low.
    always @(negedge sclk_v[0] or posedge cs_n_v[0]) begin
        if (cs_n_v[0] !== 1'b0) nf0 = 0;
        else nf0++;
    end
    always @(negedge sclk_v[1] or posedge cs_n_v[1]) begin
        if (cs_n_v[1] !== 1'b0) nf1 = 0;
        else nf1++;
    end
    assign miso_v[0] = (nf0 < 16) ? frame0[4'(15 - nf0)] : 1'b0;
    assign miso_v[1] = (nf1 < 16) ? frame1[4'(15 - nf1)] : 1'b0;

    // {cs_n, sclk, busy, done, data} packed for compact comparisons.
    localparam logic [31:0] RST_OUTS = 32'h0008_0000;

    function automatic logic [31:0] outs(int i);
        if (i == 0) return {12'h000, cs_n_v[0], sclk_v[0], busy_v[0], done_v[0], data0};
        return {12'h000, cs_n_v[1], sclk_v[1], busy_v[1], done_v[1], data1};
    endfunction

    function automatic int div_of(int i);
        return (i == 0) ? 4 : 2;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(int i, logic v);
        if (i == 0) start_v[0] = v;
        else start_v[1] = v;
    endtask

    task automatic set_frame(int i, logic [15:0] f);
        if (i == 0) frame0 = f;
        else frame1 = f;
    endtask

    task automatic clear_stats(int i);
        rises[i]      = 0;
        sclk_hi[i]    = 0;
        cs_low[i]     = 0;
        busy_hi[i]    = 0;
        dones[i]      = 0;
        done_cyc[i]   = -1;
        first_rise[i] = -1;
        last_rise[i]  = -1;
        bad_period[i] = 0;
        done_data[i]  = 16'h0000;
        sclk_prev[i]  = outs(i)[18];
    endtask

    // Advance one clock and observe both instances 1 time unit after the edge.
    task automatic step();
        logic [31:0] o;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            o = outs(i);
            if (o[18] && !sclk_prev[i]) begin
                rises[i]++;
                if (last_rise[i] >= 0 && (cyc - last_rise[i]) != 2 * div_of(i)) bad_period[i]++;
                if (first_rise[i] < 0) first_rise[i] = cyc;
                last_rise[i] = cyc;
            end
            if (o[18]) sclk_hi[i]++;
            if (!o[19]) cs_low[i]++;
            if (o[17]) busy_hi[i]++;
            if (o[16]) begin
                dones[i]++;
                done_cyc[i]  = cyc;
                done_data[i] = o[15:0];
            end
            sclk_prev[i] = o[18];
        end
    endtask

    // One frame requested by a single-cycle start pulse; optional extra start pulses
    // land at cycles 10 and 100 of the frame and must be ignored.
    task automatic run_frame(int i, logic [15:0] f, bit poke);
        int d;
        int c0;
        d = div_of(i);
        set_frame(i, f);
        clear_stats(i);
        set_start(i, 1'b1);
        step();
        c0 = cyc;
        set_start(i, 1'b0);
        for (int n = 0; n < 40 * d && dones[i] == 0; n++) begin
            if (poke && ((cyc - c0) == 9 || (cyc - c0) == 99)) set_start(i, 1'b1);
            step();
            set_start(i, 1'b0);
        end
        check("done_seen", dones[i], 1);
        check("done_latency", done_cyc[i] - c0, 33 * d);
        check("frame_data", {16'h0000, done_data[i]}, {16'h0000, f});
        check("sclk_rises", rises[i], 16);
        check("first_rise", first_rise[i] - c0, d);
        check("last_rise", last_rise[i] - c0, 31 * d);
        check("sclk_period", bad_period[i], 0);
        check("sclk_duty", sclk_hi[i], 16 * d);
        check("cs_low_len", cs_low[i], 33 * d);
        check("busy_len", busy_hi[i], 33 * d);
        for (int n = 0; n < 10; n++) step();
        check("no_extra_done", dones[i], 1);
        check("idle_after", outs(i) & 32'h000F_FFFF, {12'h000, 4'b1000, f});
    endtask

    initial begin
        logic [15:0] r;
        int d1;
        int gap;

        // Reset values, held through reset and after release with start low.
        for (int n = 0; n < 5; n++) begin
            step();
            check("rst_dut4", outs(0), RST_OUTS);
            check("rst_dut2", outs(1), RST_OUTS);
        end
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            check("post_rst_dut4", outs(0), RST_OUTS);
            check("post_rst_dut2", outs(1), RST_OUTS);
        end

        // Single frame and start-while-busy on DIV=4.
        run_frame(0, 16'hA5C3, 1'b0);
        run_frame(0, 16'h3C5A, 1'b1);

        // Back-to-back frames with start held high.
        clear_stats(0);
        frame0 = 16'h0001;
        start_v[0] = 1'b1;
        step();
        for (int n = 0; n < 160 && dones[0] == 0; n++) step();
        check("b2b_done1", dones[0], 1);
        check("b2b_data1", {16'h0000, done_data[0]}, 32'h0000_0001);
        d1 = done_cyc[0];
        frame0 = 16'hFFFE;
        gap = cs_n_v[0] ? 1 : 0;
        for (int n = 0; n < 5 && cs_n_v[0]; n++) begin
            step();
            if (cs_n_v[0]) gap++;
        end
        check("b2b_cs_gap", gap, 1);
        for (int n = 0; n < 160 && dones[0] < 2; n++) step();
        start_v[0] = 1'b0;
        check("b2b_done2", dones[0], 2);
        check("b2b_spacing", done_cyc[0] - d1, 33 * 4 + 1);
        check("b2b_data2", {16'h0000, done_data[0]}, 32'h0000_FFFE);
        for (int n = 0; n < 10; n++) step();
        check("b2b_stop", dones[0], 2);

        // Reset mid-frame: asynchronous clear, no done, partial frame discarded.
        clear_stats(0);
        frame0 = 16'h1234;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        for (int n = 0; n < 100 && rises[0] < 8; n++) step();
        check("abort_rises", rises[0], 8);
        #3;
        rst = 1'b1;
        #1;
        check("abort_async", outs(0), RST_OUTS);
        step();
        step();
        check("abort_held", outs(0), RST_OUTS);
        rst = 1'b0;
        clear_stats(0);
        for (int n = 0; n < 150; n++) step();
        check("abort_no_done", dones[0], 0);
        check("abort_cs_idle", cs_low[0], 0);
        run_frame(0, 16'h5678, 1'b0);

        // Randomized frames on DIV=4.
        for (int k = 0; k < 2; k++) begin
            r = 16'($urandom);
            run_frame(0, r, 1'($urandom_range(0, 1)));
        end

        // Minimum divider.
        run_frame(1, 16'h5555, 1'b0);
        for (int k = 0; k < 2; k++) begin
            r = 16'($urandom);
            run_frame(1, r, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
